// File: rtl/eth_pkg.sv
// Shared Ethernet receive types: AXI-Stream widths, write-side FSM states, stored beat layout.
// Imported by the frame FIFO and its storage.
package eth_pkg;

  localparam int AXIS_DATA_W             = 64;
  localparam int AXIS_KEEP_W             = 8;
  localparam int BEAT_W                  = AXIS_DATA_W + AXIS_KEEP_W + 1;
  localparam int DEFAULT_MAX_FRAME_BEATS = 190;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DROP
  } wr_state_t;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
  } beat_t;

endpackage

// File: rtl/eth_rx_fifo_ram.sv
// Simple dual-port beat storage, one write and one registered read per cycle.
// The read register clears on reset and holds its value whenever rd_en is low.
module eth_rx_fifo_ram
  import eth_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  beat_t             wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output beat_t             rd_data
);

  beat_t mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // This register doubles as the downstream output stage, hence the hold and reset.
  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive FIFO: only whole, error-free frames become visible on m_axis.
// Optional frame statistics counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH_LOG2      = 9,
  parameter int MAX_FRAME_BEATS = DEFAULT_MAX_FRAME_BEATS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            frames_good,
  output logic [31:0]            frames_dropped
);

  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(MAX_FRAME_BEATS + 2);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  wr_state_t        state, state_n;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, rd_ptr_d, occ;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n, cnt_this;
  logic             full, oversize, wr_en, rd_en, avail, good_inc, drop_inc;
  beat_t            wr_beat, rd_beat;

  assign s_axis_tready = ~reset;
  assign wr_beat  = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};

  // Occupancy uses last cycle's read pointer, so full may assert one beat early.
  assign occ      = wr_ptr - rd_ptr_d;
  assign full     = occ >= PTR_W'(DEPTH - 1);
  assign cnt_this = (state == ST_IDLE) ? CNT_W'(1) : beat_cnt + CNT_W'(1);
  assign oversize = cnt_this > CNT_W'(MAX_FRAME_BEATS);

  always_comb begin
    state_n      = state;
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    beat_cnt_n   = beat_cnt;
    wr_en        = 1'b0;
    good_inc     = 1'b0;
    drop_inc     = 1'b0;
    if (s_axis_tvalid && s_axis_tready) begin
      case (state)
        ST_IDLE, ST_RECV: begin
          if (full || oversize) begin
            wr_ptr_n = commit_ptr;
            if (s_axis_tlast) begin
              drop_inc = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              state_n  = ST_DROP;
            end
          end else if (s_axis_tlast) begin
            state_n = ST_IDLE;
            if (s_axis_tuser) begin
              wr_ptr_n = commit_ptr;
              drop_inc = 1'b1;
            end else begin
              wr_en        = 1'b1;
              wr_ptr_n     = wr_ptr + PTR_ONE;
              commit_ptr_n = wr_ptr + PTR_ONE;
              good_inc     = 1'b1;
            end
          end else begin
            wr_en      = 1'b1;
            wr_ptr_n   = wr_ptr + PTR_ONE;
            beat_cnt_n = cnt_this;
            state_n    = ST_RECV;
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign avail = commit_ptr != rd_ptr;
  assign rd_en = avail && (!m_axis_tvalid || m_axis_tready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      beat_cnt      <= '0;
      rd_ptr        <= '0;
      rd_ptr_d      <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_n;
      wr_ptr        <= wr_ptr_n;
      commit_ptr    <= commit_ptr_n;
      beat_cnt      <= beat_cnt_n;
      rd_ptr        <= rd_en ? rd_ptr + PTR_ONE : rd_ptr;
      rd_ptr_d      <= rd_ptr;
      m_axis_tvalid <= rd_en || (m_axis_tvalid && !m_axis_tready);
    end
  end

  eth_rx_fifo_ram #(.ADDR_W(DEPTH_LOG2)) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (rd_beat)
  );

  assign m_axis_tdata = rd_beat.data;
  assign m_axis_tkeep = rd_beat.keep;
  assign m_axis_tlast = rd_beat.last;

`ifdef ETH_RX_STATS_EN
  logic [31:0] good_q, drop_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      good_q <= '0;
      drop_q <= '0;
    end else begin
      if (good_inc && good_q != '1) good_q <= good_q + 32'd1;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + 32'd1;
    end
  end

  assign frames_good    = good_q;
  assign frames_dropped = drop_q;
`else
  logic unused_stats;
  assign unused_stats   = good_inc | drop_inc;
  assign frames_good    = '0;
  assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo: directed frame scenarios plus randomized frames against a frame-level model.
module tb_eth_rx_frame_fifo;
  import eth_pkg::*;

  localparam int DLOG = 4;
  localparam int MAXB = 12;
`ifdef ETH_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0, s_tuser = 1'b0, s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] frames_good, frames_dropped;

  always #5 clock = ~clock;

  eth_rx_frame_fifo #(.DEPTH_LOG2(DLOG), .MAX_FRAME_BEATS(MAXB)) dut (
    .clock          (clock),
    .reset          (reset),
    .s_axis_tdata   (s_tdata),
    .s_axis_tkeep   (s_tkeep),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .frames_good    (frames_good),
    .frames_dropped (frames_dropped)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];
  int          exp_good = 0;
  int          exp_drop = 0;
  int          rdy_mode = 0;
  logic        stall_prev = 1'b0;
  logic [72:0] hold_beat = '0;
  logic [72:0] cur;

  assign cur = {m_tdata, m_tkeep, m_tlast};

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] cnt_exp(input int v);
    return STATS ? 73'(v) : 73'(0);
  endfunction

  // Output ready pattern: 0 low, 1 high, 2 toggle, otherwise random.
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      2:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom % 2);
    endcase
  end

  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 73'(m_tvalid), 73'(1));
        chk("hold_beat", cur, hold_beat);
      end
      if (m_tvalid && m_tready) got_q.push_back(cur);
      stall_prev = m_tvalid && !m_tready;
      hold_beat  = cur;
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int len, input bit bad, input bit force_drop,
                            input logic [7:0] lkeep, input bit bubbles);
    logic [72:0] beats[$];
    logic [63:0] d;
    logic [7:0]  k;
    bit          last;
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      d    = {$urandom, $urandom};
      k    = !last ? 8'hFF : (lkeep != 8'h00 ? lkeep : 8'($urandom_range(1, 255)));
      if (bubbles && ($urandom % 4 == 0)) begin
        s_tvalid = 1'b0;
        step;
      end
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = last;
      s_tuser  = last ? bad : 1'($urandom % 2);
      s_tvalid = 1'b1;
      step;
      beats.push_back({d, k, last});
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (force_drop || bad || len > MAXB) exp_drop++;
    else begin
      exp_good++;
      foreach (beats[i]) exp_q.push_back(beats[i]);
    end
  endtask

  task automatic drain_check(input string tag);
    for (int c = 0; c < 600 && got_q.size() < exp_q.size(); c++) step;
    repeat (4) step;
    chk({tag, "_count"}, 73'(got_q.size()), 73'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_beat"}, got_q[i], exp_q[i]);
    chk({tag, "_good"}, 73'(frames_good), cnt_exp(exp_good));
    chk({tag, "_dropped"}, 73'(frames_dropped), cnt_exp(exp_drop));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    step;
    step;
    chk("rst_s_tready", 73'(s_tready), 73'(0));
    chk("rst_m_tvalid", 73'(m_tvalid), 73'(0));
    chk("rst_m_beat", cur, 73'(0));
    chk("rst_good", 73'(frames_good), 73'(0));
    chk("rst_dropped", 73'(frames_dropped), 73'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_s_tready", 73'(s_tready), 73'(1));
    got_q.delete();
    exp_q.delete();
    exp_good = 0;
    exp_drop = 0;
  endtask

  initial begin
    rdy_mode = 1;
    do_reset;

    // Good 8-beat frame; first beat visible two cycles after the commit cycle.
    send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0);
    chk("lat_commit_cycle", 73'(m_tvalid), 73'(0));
    step;
    chk("lat_plus2_valid", 73'(m_tvalid), 73'(1));
    chk("lat_plus2_beat", cur, exp_q[0]);
    drain_check("good8");

    // Bad frame followed by a good one.
    send_frame(8, 1'b1, 1'b0, 8'h00, 1'b0);
    send_frame(4, 1'b0, 1'b0, 8'h00, 1'b0);
    drain_check("bad_then_good");

    // Overflow with the consumer stalled: third 6-beat frame cannot fit.
    rdy_mode = 0;
    step;
    send_frame(6, 1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(6, 1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(6, 1'b0, 1'b1, 8'h00, 1'b0);
    repeat (3) step;
    chk("ovf_stalled_valid", 73'(m_tvalid), 73'(1));
    chk("ovf_stalled_beat", cur, exp_q[0]);
    rdy_mode = 1;
    drain_check("overflow");

    // Length boundary: one beat over the limit drops, exactly the limit passes.
    send_frame(MAXB + 1, 1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(MAXB, 1'b0, 1'b0, 8'h00, 1'b0);
    send_frame(3, 1'b0, 1'b0, 8'h00, 1'b0);
    drain_check("oversize");

    // Toggling backpressure during a 10-beat frame.
    rdy_mode = 2;
    send_frame(10, 1'b0, 1'b0, 8'h00, 1'b0);
    drain_check("toggle");

    // Committed data plus a partial frame, then reset: all of it must vanish.
    rdy_mode = 0;
    send_frame(4, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = 8'hFF;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      step;
    end
    do_reset;
    rdy_mode = 1;
    send_frame(2, 1'b0, 1'b0, 8'h00, 1'b0);
    drain_check("reset_mid");

    // Randomized frames with bubbles and random consumer readiness.
    rdy_mode = 3;
    for (int f = 0; f < 25; f++) begin
      send_frame($urandom_range(1, MAXB + 2), ($urandom % 4 == 0), 1'b0, 8'h00, 1'b1);
      repeat ($urandom_range(0, 3)) step;
      drain_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_fifo.md
ETH_RX_FRAME_FIFO -- requirements
Module: eth_rx_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, meaning buffer depth is 2^DEPTH_LOG2 beats.
REQ-002 SHALL have parameter MAX_FRAME_BEATS, default 190, meaning the longest accepted frame in 64-bit beats.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clock  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  in  64  receive beat data from the Ethernet MAC.
REQ-006 s_axis_tkeep  in  8  byte-valid mask.
REQ-007 s_axis_tlast  in  1  last beat of frame.
REQ-008 s_axis_tuser  in  1  frame error (bad FCS or PHY error); sampled on the tlast beat only.
REQ-009 s_axis_tvalid  in  1  beat valid.
REQ-010 s_axis_tready  out  1  always 1 after reset; the MAC is never stalled.
REQ-011 m_axis_tdata/tkeep/tlast/tvalid  out  64/8/1/1  good-frame stream to the RISC-V side.
REQ-012 m_axis_tready  in  1  consumer ready.
REQ-013 frames_good  out  32  count of committed frames.
REQ-014 frames_dropped  out  32  count of discarded frames.

Function
REQ-015 SHALL store tdata, tkeep and tlast per beat (73 bits) at wr_ptr; pointers SHALL be DEPTH_LOG2+1 bits wide with wrap bit.
REQ-016 SHALL keep a commit pointer; only beats below the commit pointer SHALL be visible on m_axis.
REQ-017 Write FSM states SHALL be IDLE, RECV, DROP.
REQ-018 IDLE: a valid beat SHALL be written; the FSM goes to RECV, or commits or drops immediately if tlast=1.
REQ-019 RECV: on tlast with tuser=0, commit_ptr SHALL become wr_ptr+1 and frames_good SHALL increment in the same cycle.
REQ-020 RECV: on tlast with tuser=1, wr_ptr SHALL rewind to commit_ptr, frames_dropped SHALL increment, and the FSM returns to IDLE.
REQ-021 Buffer full (wr_ptr+1 == rd_ptr modulo wrap) on an incoming non-last beat SHALL rewind wr_ptr and enter DROP.
REQ-022 Buffer full on a tlast beat SHALL drop the frame and return to IDLE.
REQ-023 A beat count exceeding MAX_FRAME_BEATS SHALL rewind wr_ptr and enter DROP.
REQ-024 DROP SHALL discard beats until tlast, then increment frames_dropped once and return to IDLE.
REQ-025 Read side SHALL use a one-entry registered output stage.
REQ-026 Data transfers when m_axis_tvalid && m_axis_tready.
REQ-027 m_axis data SHALL hold stable while tvalid=1 and tready=0.
REQ-028 Latency: the first beat of a frame SHALL appear on m_axis 2 cycles after its commit cycle, given tready=1.
REQ-029 Sustained output throughput SHALL be 1 beat/cycle.
REQ-030 A simultaneous commit and read SHALL both take effect.
REQ-031 Full SHALL be evaluated against the read pointer of the previous cycle, which is conservative.
REQ-032 Counters SHALL saturate at 0xFFFFFFFF.

Reset
REQ-033 On reset: pointers 0, FSM IDLE, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, counters 0.
REQ-034 s_axis_tready SHALL be 0 during reset and 1 from the first cycle after reset.
REQ-035 Reset mid-frame SHALL discard the partial frame and all uncommitted and committed data without counting it.

Configuration
REQ-036 Macro ETH_RX_STATS_EN defined: frames_good and frames_dropped SHALL be implemented as above.
REQ-037 ETH_RX_STATS_EN undefined: both counter outputs SHALL be tied to 0, with no counter flops; all other behaviour is unchanged.

Structure
REQ-038 Shared package eth_pkg SHALL hold AXIS_DATA_W=64, AXIS_KEEP_W=8, the write-FSM state enum and the default MAX_FRAME_BEATS.
REQ-039 The storage SHALL be one sub-module eth_rx_fifo_ram: simple dual-port, 73 bits x 2^DEPTH_LOG2, registered read.

Verification
REQ-040 Good frame: 8 beats, tuser=0, last tkeep=0x0F, tready=1 -> same 8 beats out starting commit+2, last tkeep=0x0F, frames_good=1.
REQ-041 Bad frame: 8-beat frame with tuser=1 on tlast, then a good 4-beat frame -> only the 4 beats are output, frames_dropped=1, frames_good=1.
REQ-042 Overflow: DEPTH_LOG2=4, tready=0, frames of 6/6/6 beats -> first two committed, third dropped (frames_dropped=1); after tready=1, exactly 12 beats are output.
REQ-043 Oversize: MAX_FRAME_BEATS=4, 6-beat good frame -> no output, frames_dropped=1, next 3-beat frame passes.
REQ-044 Backpressure: toggle tready every cycle during a 10-beat frame -> data stable while stalled, 10 beats in order, no duplicates.
REQ-045 Reset mid-frame at beat 3 of 8, then a new 2-beat good frame -> output is only the 2 beats, frames_good=1, frames_dropped=0.
